// File: rtl/hps_spi_bridge.sv
// HPS-to-fabric SPI bridge: input synchronisers, mode-0 SPI word (de)serialiser, FWFT RX FIFO.
// Optional word counter output enabled by defining HPS_SPI_WORDCNT_EN.
module hps_spi_bridge #(
    parameter int WORD_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_EN      = 3
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    input  logic [NUM_EN-1:0] en_in,
    output logic [NUM_EN-1:0] en_sync,
    input  logic [WORD_W-1:0] tx_word,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overflow,
    input  logic              ovf_clr,
    output logic              word_strobe,
    output logic              frame_active
`ifdef HPS_SPI_WORDCNT_EN
   ,output logic [15:0]       word_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_W);

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    logic [SYNC_STAGES-1:0]             sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]             mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]             cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][NUM_EN-1:0] en_sync_q, en_sync_d;
    logic                               sck_prev_q, sck_prev_d;
    logic                               cs_prev_q, cs_prev_d;
    state_t                             state_q, state_d;
    logic                               frame_active_q, frame_active_d;
    logic [CW-1:0]                      bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]                  rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0]                  tx_shift_q, tx_shift_d;
    logic                               reload_q, reload_d;
    logic                               word_strobe_q, word_strobe_d;
    logic [AW:0]                        wr_ptr_q, wr_ptr_d;
    logic [AW:0]                        rd_ptr_q, rd_ptr_d;
    logic                               ovf_q, ovf_d;
    logic [WORD_W-1:0]                  fifo_mem [FIFO_DEPTH];
`ifdef HPS_SPI_WORDCNT_EN
    logic [15:0]                        word_count_q, word_count_d;
`endif

    logic              sck_s, mosi_s, cs_s;
    logic              sck_rise, sck_fall, cs_fall, cs_rise;
    logic              push, push_ok, pop, fifo_empty, fifo_full;
    logic [AW:0]       fifo_count;
    logic [WORD_W-1:0] push_word;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        en_sync_d   = en_sync_q;
        en_sync_d[0] = en_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            en_sync_d[i] = en_sync_q[i-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    always_comb begin
        state_d        = state_q;
        frame_active_d = frame_active_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        reload_d       = reload_q;
        word_strobe_d  = 1'b0;
        push           = 1'b0;
        push_word      = {rx_shift_q[WORD_W-2:0], mosi_s};
        sck_prev_d     = sck_s;
        cs_prev_d      = cs_s;
`ifdef HPS_SPI_WORDCNT_EN
        word_count_d   = word_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d        = ST_FRAME;
                    frame_active_d = 1'b1;
                    bit_cnt_d      = '0;
                    tx_shift_d     = tx_word;
                    reload_d       = 1'b0;
`ifdef HPS_SPI_WORDCNT_EN
                    word_count_d   = '0;
`endif
                end
            end
            ST_FRAME: begin
                if (cs_rise) begin
                    // partial word is simply abandoned in rx_shift_q
                    state_d        = ST_IDLE;
                    frame_active_d = 1'b0;
                    bit_cnt_d      = '0;
                    reload_d       = 1'b0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = push_word;
                        if (bit_cnt_q == CW'(WORD_W - 1)) begin
                            bit_cnt_d     = '0;
                            push          = 1'b1;
                            word_strobe_d = 1'b1;
                            reload_d      = 1'b1;
`ifdef HPS_SPI_WORDCNT_EN
                            if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    if (sck_fall) begin
                        if (reload_q) begin
                            tx_shift_d = tx_word;
                            reload_d   = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & rx_ready;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok    = push & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        if (push & fifo_full & ~pop) ovf_d = 1'b1;
        else if (ovf_clr)            ovf_d = 1'b0;
        else                         ovf_d = ovf_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_sync_q     <= '0;
            mosi_sync_q    <= '0;
            cs_sync_q      <= '1;
            en_sync_q      <= '0;
            sck_prev_q     <= 1'b0;
            cs_prev_q      <= 1'b1;
            state_q        <= ST_IDLE;
            frame_active_q <= 1'b0;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            reload_q       <= 1'b0;
            word_strobe_q  <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ovf_q          <= 1'b0;
`ifdef HPS_SPI_WORDCNT_EN
            word_count_q   <= '0;
`endif
        end else begin
            sck_sync_q     <= sck_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            cs_sync_q      <= cs_sync_d;
            en_sync_q      <= en_sync_d;
            sck_prev_q     <= sck_prev_d;
            cs_prev_q      <= cs_prev_d;
            state_q        <= state_d;
            frame_active_q <= frame_active_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            reload_q       <= reload_d;
            word_strobe_q  <= word_strobe_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ovf_q          <= ovf_d;
`ifdef HPS_SPI_WORDCNT_EN
            word_count_q   <= word_count_d;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= push_word;
    end

    assign en_sync      = en_sync_q[SYNC_STAGES-1];
    assign rx_valid     = ~fifo_empty;
    assign rx_word      = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign rx_overflow  = ovf_q;
    assign word_strobe  = word_strobe_q;
    assign frame_active = frame_active_q;
    assign spi_miso     = frame_active_q & tx_shift_q[WORD_W-1];
`ifdef HPS_SPI_WORDCNT_EN
    assign word_count   = word_count_q;
`endif

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Self-checking bench for hps_spi_bridge: word-level FIFO model checked every cycle plus directed literals.
module tb_hps_spi_bridge;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
    logic        spi_miso;
    logic [2:0]  en_in = 3'b000;
    logic [2:0]  en_sync;
    logic [15:0] tx_word = 16'h0000;
    logic [15:0] rx_word;
    logic        rx_valid, rx_ready = 1'b0, rx_overflow, ovf_clr = 1'b0;
    logic        word_strobe, frame_active;
`ifdef HPS_SPI_WORDCNT_EN
    logic [15:0] word_count;
`endif

    hps_spi_bridge #(.WORD_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2), .NUM_EN(3)) dut (
        .clk_sys(clk_sys), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs(spi_cs), .spi_miso(spi_miso), .en_in(en_in), .en_sync(en_sync),
        .tx_word(tx_word), .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .word_strobe(word_strobe),
        .frame_active(frame_active)
`ifdef HPS_SPI_WORDCNT_EN
       ,.word_count(word_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    bit pop_align = 1'b0;

    logic [15:0] sent_q[$];   // full words sent on MOSI, not yet accounted
    logic [15:0] model_q[$];  // expected FIFO contents
    logic        exp_ovf = 1'b0;
    logic        prev_pop = 1'b0, prev_clr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    // One SPI bit = 5 cycles low + 5 cycles high; MISO sampled just before the rising edge.
    task automatic send_bits(input logic [15:0] val, input int n);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = val[n-1-i];
            cyc(4);
            got = {got[14:0], spi_miso};
            cyc(1);
            if (i == n - 1 && n == 16) sent_q.push_back(val);
            spi_clk = 1'b1;
            if (pop_align && i == n - 1) begin
                cyc(2);
                rx_ready = 1'b1;
                cyc(1);
                rx_ready = 1'b0;
                cyc(2);
            end else begin
                cyc(5);
            end
            spi_clk = 1'b0;
        end
        if (n == 16) chk("miso_word", got, tx_word);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        cyc(5);
    endtask

    task automatic cs_high();
        cyc(5);
        spi_cs = 1'b1;
        cyc(5);
    endtask

    task automatic pop_check(input logic [15:0] exp);
        chk("pop_valid", rx_valid, 1);
        chk("pop_word", rx_word, exp);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    // Word-level model: each strobe consumes the next fully sent word; pops observed at the prior cycle.
    initial begin
        logic drop;
        logic [15:0] w;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                model_q.delete();
                sent_q.delete();
                exp_ovf  = 1'b0;
                prev_pop = 1'b0;
                prev_clr = 1'b0;
            end else begin
                drop = 1'b0;
                if (prev_pop && model_q.size() > 0) void'(model_q.pop_front());
                if (word_strobe) begin
                    strobe_cnt++;
                    if (sent_q.size() == 0) begin
                        chk("strobe_without_word", 1, 0);
                    end else begin
                        w = sent_q.pop_front();
                        if (model_q.size() < DEPTH) model_q.push_back(w);
                        else drop = 1'b1;
                    end
                end
                if (drop)          exp_ovf = 1'b1;
                else if (prev_clr) exp_ovf = 1'b0;
                chk("model_rx_valid", rx_valid, model_q.size() != 0);
                if (model_q.size() != 0) chk("model_rx_word", rx_word, model_q[0]);
                chk("model_rx_overflow", rx_overflow, exp_ovf);
                prev_pop = rx_valid & rx_ready;
                prev_clr = ovf_clr;
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int s0;
        cyc(3);
        reset = 1'b0;
        cyc(3);

        // Preamble: leave a word in the FIFO and a frame open, then reset mid-run.
        en_in   = 3'b111;
        tx_word = 16'h8000;
        cs_low();
        send_bits(16'h5A5A, 16);
        cyc(5);
        chk("pre_frame_active", frame_active, 1);
        chk("pre_rx_valid", rx_valid, 1);
        chk("pre_miso_reload", spi_miso, 1);
        #1;
        reset = 1'b1;
        en_in = 3'b000;
        #1;
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_word", rx_word, 0);
        chk("rst_rx_overflow", rx_overflow, 0);
        chk("rst_word_strobe", word_strobe, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_spi_miso", spi_miso, 0);
        chk("rst_en_sync", en_sync, 0);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(3);
        s0 = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            spi_clk = 1'b1; cyc(5); spi_clk = 1'b0; cyc(5);
        end
        chk("cs_high_no_strobe", strobe_cnt - s0, 0);
        chk("cs_high_no_push", rx_valid, 0);

        // Single word with MISO payload
        tx_word = 16'h1234;
        s0 = strobe_cnt;
        cs_low();
        send_bits(16'hA5C3, 16);
        cs_high();
        chk("t2_one_strobe", strobe_cnt - s0, 1);
        chk("t2_miso_idle", spi_miso, 0);
        pop_check(16'hA5C3);
        chk("t2_empty_after_pop", rx_valid, 0);

        // Overflow on fifth word
        s0 = strobe_cnt;
        cs_low();
        for (int i = 1; i <= 5; i++) send_bits(16'(i), 16);
        cs_high();
        chk("t3_strobes", strobe_cnt - s0, 5);
        chk("t3_overflow_set", rx_overflow, 1);
        for (int i = 1; i <= 4; i++) pop_check(16'(i));
        chk("t3_empty", rx_valid, 0);
        chk("t3_overflow_sticky", rx_overflow, 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        cyc(1);
        chk("t3_overflow_clr", rx_overflow, 0);

        // Push and pop coincide while full
        cs_low();
        for (int i = 2; i <= 5; i++) send_bits(16'(i), 16);
        cyc(5);
        chk("t4_full_no_ovf", rx_overflow, 0);
        pop_align = 1'b1;
        send_bits(16'h0006, 16);
        pop_align = 1'b0;
        cs_high();
        chk("t4_no_overflow", rx_overflow, 0);
        for (int i = 3; i <= 6; i++) pop_check(16'(i));
        chk("t4_empty", rx_valid, 0);

        // Partial word discarded
        s0 = strobe_cnt;
        cs_low();
        send_bits(16'h01AB, 9);
        cs_high();
        chk("t5_partial_no_strobe", strobe_cnt - s0, 0);
        chk("t5_partial_no_push", rx_valid, 0);
        cs_low();
        send_bits(16'hBEEF, 16);
        cs_high();
        chk("t5_one_strobe", strobe_cnt - s0, 1);
`ifdef HPS_SPI_WORDCNT_EN
        chk("t5_word_count", word_count, 1);
`endif
        pop_check(16'hBEEF);
        chk("t5_empty", rx_valid, 0);

        // Enable and chip-select synchroniser latency
        en_in = 3'b101;
        cyc(1);
        chk("t6_en_not_yet", en_sync, 3'b000);
        cyc(2);
        chk("t6_en_sync", en_sync, 3'b101);
        spi_cs = 1'b0;
        cyc(1);
        chk("t6_fa_not_yet", frame_active, 0);
        cyc(2);
        chk("t6_fa_set", frame_active, 1);
        spi_cs = 1'b1;
        cyc(3);
        chk("t6_fa_clr", frame_active, 0);
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
